// File: rtl/vector_dot_pkg.sv
// Shared definitions for the vector dot-product sequencer: FSM encoding,
// operand capacity and fixed engine register addresses.
package vector_dot_pkg;

    localparam int unsigned MAX_LEN = 6;

    localparam logic [2:0] ENG_TRIG_ADDR = 3'd0;
    localparam logic [2:0] ENG_RES_ADDR  = 3'd0;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_A   = 4'd1,
        S_WT_A   = 4'd2,
        S_WR_A   = 4'd3,
        S_RD_B   = 4'd4,
        S_WT_B   = 4'd5,
        S_WR_B   = 4'd6,
        S_TRIG   = 4'd7,
        S_WAIT   = 4'd8,
        S_RD_RES = 4'd9,
        S_CAP    = 4'd10,
        S_WR_MEM = 4'd11,
        S_DONE   = 4'd12
    } state_e;

endpackage

// File: rtl/vector_dot_mem_rd.sv
// Memory read handshake shared by the A and B operand phases: holds the request
// through waitrequest, then captures the word returned under readdatavalid.
module vector_dot_mem_rd (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rd_req_i,
    input  logic        wt_req_i,
    input  logic [31:0] addr_i,
    input  logic        mem_waitrequest_i,
    input  logic        mem_readdatavalid_i,
    input  logic [31:0] mem_readdata_i,
    output logic        mem_read_o,
    output logic [31:0] mem_address_o,
    output logic        accept_o,
    output logic        capture_o,
    output logic [31:0] data_o
);

    logic [31:0] data_q;
    logic [31:0] data_d;

    // Request decode and capture qualification; readdatavalid outside the wait phase is dropped.
    always_comb begin
        mem_read_o = rd_req_i;
        if (rd_req_i) begin
            mem_address_o = addr_i;
        end else begin
            mem_address_o = 32'd0;
        end
        accept_o  = rd_req_i & ~mem_waitrequest_i;
        capture_o = wt_req_i & mem_readdatavalid_i;
        if (capture_o) begin
            data_d = mem_readdata_i;
        end else begin
            data_d = data_q;
        end
    end

    // Captured read word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= 32'd0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/vector_dot_sequencer.sv
// Sequencer that streams two vectors from memory into a dot-product engine,
// triggers it, reads back the result and writes it to a destination word.
module vector_dot_sequencer
    import vector_dot_pkg::*;
#(
    parameter int unsigned MAX_LEN = vector_dot_pkg::MAX_LEN,
    parameter int unsigned ENG_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  len,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] dst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    output logic [2:0]  eng_address,
    output logic [31:0] eng_writedata,
    output logic        eng_write,
    output logic        eng_read,
    output logic        eng_b_data,
    input  logic [31:0] eng_readdata
);

    localparam logic [7:0] LAT_LAST = 8'(ENG_LAT - 1);
    localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);

    state_e      state_q,  state_d;
    logic [2:0]  idx_q,    idx_d;
    logic [2:0]  len_q,    len_d;
    logic [31:0] src_a_q,  src_a_d;
    logic [31:0] src_b_q,  src_b_d;
    logic [31:0] dst_q,    dst_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  lat_q,    lat_d;
    logic        err_q,    err_d;

    logic        len_ok_s;
    logic        rd_req_s;
    logic        wt_req_s;
    logic        b_phase_s;
    logic [31:0] rd_addr_s;
    logic        rd_accept_s;
    logic        rd_capture_s;
    logic        rd_mem_read_s;
    logic [31:0] rd_mem_address_s;
    logic [31:0] rd_data_s;

    assign len_ok_s  = (len != 3'd0) && ({29'd0, len} <= MAX_LEN_W);
    assign rd_req_s  = (state_q == S_RD_A) || (state_q == S_RD_B);
    assign wt_req_s  = (state_q == S_WT_A) || (state_q == S_WT_B);
    assign b_phase_s = (state_q == S_RD_B) || (state_q == S_WT_B) || (state_q == S_WR_B);
    // Element address wraps modulo 2^32 by plain 32-bit addition.
    assign rd_addr_s = (b_phase_s ? src_b_q : src_a_q) + {29'd0, idx_q};

    vector_dot_mem_rd u_mem_rd (
        .clk_i               (clk),
        .rst_ni              (reset),
        .rd_req_i            (rd_req_s),
        .wt_req_i            (wt_req_s),
        .addr_i              (rd_addr_s),
        .mem_waitrequest_i   (mem_waitrequest),
        .mem_readdatavalid_i (mem_readdatavalid),
        .mem_readdata_i      (mem_readdata),
        .mem_read_o          (rd_mem_read_s),
        .mem_address_o       (rd_mem_address_s),
        .accept_o            (rd_accept_s),
        .capture_o           (rd_capture_s),
        .data_o              (rd_data_s)
    );

    // Next-state logic for the command sequence.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        result_d = result_q;
        lat_d    = lat_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && len_ok_s) begin
                    len_d   = len;
                    src_a_d = src_a;
                    src_b_d = src_b;
                    dst_d   = dst;
                    idx_d   = 3'd0;
                    state_d = S_RD_A;
                end else if (start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_A: begin
                if (rd_accept_s) begin
                    state_d = S_WT_A;
                end else begin
                    state_d = S_RD_A;
                end
            end
            S_WT_A: begin
                if (rd_capture_s) begin
                    state_d = S_WR_A;
                end else begin
                    state_d = S_WT_A;
                end
            end
            S_WR_A: begin
                if (idx_q == len_q - 3'd1) begin
                    idx_d   = 3'd0;
                    state_d = S_RD_B;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_RD_A;
                end
            end
            S_RD_B: begin
                if (rd_accept_s) begin
                    state_d = S_WT_B;
                end else begin
                    state_d = S_RD_B;
                end
            end
            S_WT_B: begin
                if (rd_capture_s) begin
                    state_d = S_WR_B;
                end else begin
                    state_d = S_WT_B;
                end
            end
            S_WR_B: begin
                if (idx_q == len_q - 3'd1) begin
                    idx_d   = 3'd0;
                    state_d = S_TRIG;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_RD_B;
                end
            end
            S_TRIG: begin
                lat_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_RD_RES;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            S_RD_RES: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                result_d = eng_readdata;
                state_d  = S_WR_MEM;
            end
            S_WR_MEM: begin
                if (!mem_waitrequest) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR_MEM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and command latches; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            len_q    <= 3'd0;
            src_a_q  <= 32'd0;
            src_b_q  <= 32'd0;
            dst_q    <= 32'd0;
            result_q <= 32'd0;
            lat_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            result_q <= result_d;
            lat_q    <= lat_d;
            err_q    <= err_d;
        end
    end

    // Bus and status outputs decoded from the registered state only.
    always_comb begin
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        err           = err_q;
        result        = result_q;
        mem_read      = rd_mem_read_s;
        mem_write     = (state_q == S_WR_MEM);
        eng_write     = 1'b0;
        eng_read      = 1'b0;
        eng_b_data    = 1'b0;
        eng_address   = 3'd0;
        eng_writedata = 32'd0;
        if (mem_write) begin
            mem_address   = dst_q;
            mem_writedata = result_q;
        end else begin
            mem_address   = rd_mem_address_s;
            mem_writedata = 32'd0;
        end
        case (state_q)
            S_WR_A: begin
                eng_write     = 1'b1;
                eng_address   = idx_q;
                eng_writedata = rd_data_s;
            end
            S_WR_B: begin
                eng_write     = 1'b1;
                eng_b_data    = 1'b1;
                eng_address   = idx_q;
                eng_writedata = rd_data_s;
            end
            S_TRIG: begin
                eng_write   = 1'b1;
                eng_b_data  = 1'b1;
                eng_address = ENG_TRIG_ADDR;
            end
            S_RD_RES: begin
                eng_read    = 1'b1;
                eng_address = ENG_RES_ADDR;
            end
            default: begin
                eng_write = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/vector_dot_sequencer.md
VECTOR_DOT_SEQUENCER -- requirements
Module: vector_dot_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 6: maximum element count per vector; the engine holds 6 operands per vector.
REQ-002 Parameter ENG_LAT, default 1: cycles between the engine trigger write and the result read.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle command pulse.
REQ-006 len  in  3  element count per vector.
REQ-007 src_a, src_b, dst  in  32 each  word addresses of vector A, vector B and the result slot.
REQ-008 busy  out  1  high from the start-acceptance cycle until DONE.
REQ-009 done  out  1  one-cycle pulse on completion; err  out  1  one-cycle pulse on a rejected command.
REQ-010 result  out  32  last captured dot product.
REQ-011 mem_address out 32, mem_read out 1, mem_write out 1, mem_writedata out 32, mem_readdata in 32, mem_waitrequest in 1, mem_readdatavalid in 1: memory master port.
REQ-012 eng_address out 3, eng_writedata out 32, eng_write out 1, eng_read out 1, eng_b_data out 1, eng_readdata in 32: port to the dot-product engine slave.

Function
REQ-013 Start handling: start in IDLE with 1<=len<=MAX_LEN is latched together with len, src_a, src_b and dst; start while busy is ignored.
REQ-014 Rejected commands: start in IDLE with len=0 or len>MAX_LEN pulses err for 1 cycle, issues no bus transactions and leaves busy low.
REQ-015 FSM states and order: IDLE, RD_A, WT_A, WR_A, RD_B, WT_B, WR_B, TRIG, WAIT, RD_RES, CAP, WR_MEM, DONE.
REQ-016 RD_x drives mem_read=1 and mem_address=src_x+i; both stay stable while mem_waitrequest=1; the state advances to WT_x on the first cycle with waitrequest=0.
REQ-017 WT_x holds until mem_readdatavalid=1, then latches mem_readdata; readdatavalid in any other state is ignored.
REQ-018 WR_x drives eng_write=1 for exactly 1 cycle with eng_address=i, eng_writedata=the latched word, and eng_b_data=0 for A or 1 for B.
REQ-019 Element loop: i increments after each WR_x; after i=len-1 the index i resets to 0 and the FSM moves from WR_A to RD_B or from WR_B to TRIG.
REQ-020 TRIG: 1-cycle engine write with eng_address=0, eng_writedata=0, eng_b_data=1; this is the compute trigger.
REQ-021 WAIT counts ENG_LAT cycles; RD_RES drives eng_read=1 with eng_address=0 for 1 cycle; CAP latches eng_readdata into result.
REQ-022 WR_MEM drives mem_write=1, mem_address=dst and mem_writedata=result, held while mem_waitrequest=1.
REQ-023 DONE pulses done, deasserts busy and returns to IDLE.
REQ-024 Bus strobe exclusivity: mem_read and mem_write are never both high, and eng_write and eng_read are never both high.
REQ-025 Address arithmetic: src+i is modulo 2^32, so it wraps past 0xFFFFFFFF without error.
REQ-026 Latency: with waitrequest=0 and readdatavalid one cycle after acceptance, busy lasts exactly 6*len+ENG_LAT+5 cycles.
REQ-027 Elements i>=len: the sequencer leaves engine slots i>=len unwritten, and the engine's prior contents there are the caller's responsibility.

Reset
REQ-028 Reset assertion: reset=0 forces IDLE immediately, even mid-operation, and clears i, all latches and result to 0.
REQ-029 Outputs during reset: every output is 0 while reset=0.
REQ-030 After release: the first start is accepted one cycle after release; an operation interrupted by reset is lost, not resumed.

Structure
REQ-031 Package: the FSM state enum, MAX_LEN, and the engine address constants (trigger address 0, result address 0) live in vector_dot_pkg.
REQ-032 Sub-module: the single sub-module is vector_dot_mem_rd, which owns the read/waitrequest/readdatavalid handshake and is instantiated once for the A and B phases.

Verification
REQ-033 Full-length run: A=B=1.0..6.0 (0x3F800000..0x40C00000), len=6, ENG_LAT=1, no stalls -> result=0x42B60000 (91.0) written to dst, done after 42 cycles.
REQ-034 Short run: len=2, A={1.0,2.0}, B={3.0,4.0} -> result=0x41300000 (11.0); no engine writes to addresses 2..5.
REQ-035 Stalls: waitrequest=1 for 3 cycles on every read, and readdatavalid delayed 4 cycles -> same 0x42B60000, with mem_address/mem_read stable throughout each stall.
REQ-036 Command filtering: start with len=0, then len=7 -> err pulses each time with zero bus activity; start during busy -> ignored and the original run completes unchanged.
REQ-037 Reset mid-operation: reset=0 during WT_B -> all outputs 0 in the same cycle; a fresh len=6 run afterwards yields 0x42B60000.
REQ-038 Address wrap: src_a=0xFFFFFFFE with len=4 -> reads issued at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
